// File: rtl/baud_generator_frac.sv
// Fractional baud strobe generator: the carry of a phase accumulator gives sample_ENABLE, and every OVERSAMPLE-th carry also gives tx_ENABLE.
// All outputs are registered and follow the carry by one clk; strobes run freely with no backpressure, and a rate change restarts the phase at 0.
module baud_generator_frac #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           baud_select,
  input  logic                 custom_mode,
  input  logic [ACC_WIDTH-1:0] custom_incr,
  output logic                 sample_ENABLE,
  output logic                 tx_ENABLE,
  output logic                 rate_changed
);

  localparam int unsigned     OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  function automatic logic [63:0] calc_inc(input logic [63:0] baud);
    logic [63:0] num;
    num = (baud * 64'(OVERSAMPLE)) << ACC_WIDTH;
    return (num + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
  endfunction

  localparam logic [63:0] INC_TAB [8] = '{
    calc_inc(64'd300),   calc_inc(64'd1200),  calc_inc(64'd4800),  calc_inc(64'd9600),
    calc_inc(64'd19200), calc_inc(64'd38400), calc_inc(64'd57600), calc_inc(64'd115200)
  };

  if (OVERSAMPLE < 2 || OVERSAMPLE > 64 || ACC_WIDTH < 16 || ACC_WIDTH > 32) begin : g_param_bad
    $error("baud_generator_frac: OVERSAMPLE or ACC_WIDTH out of range");
  end

  // Each table increment must be nonzero and below half scale so at most one carry per clk.
  for (genvar k = 0; k < 8; k++) begin : g_inc_chk
    if (INC_TAB[k] == 64'd0 || INC_TAB[k] >= (64'd1 << (ACC_WIDTH - 1))) begin : g_bad
      $error("baud_generator_frac: table increment %0d out of range", k);
    end
  end

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic                 sample_enable_q, sample_enable_d;
  logic                 tx_enable_q, tx_enable_d;
  logic                 rate_changed_q, rate_changed_d;

  logic [ACC_WIDTH-1:0] eff_inc;
  logic [ACC_WIDTH:0]   sum;
  logic                 rate_chg;

  assign eff_inc  = custom_mode ? custom_incr : INC_TAB[baud_select][ACC_WIDTH-1:0];
  assign rate_chg = (eff_inc != inc_q);
  assign sum      = {1'b0, acc_q} + {1'b0, inc_q};

  // A rate change and enable=0 clear the same state; only rate_changed differs.
  always_comb begin
    inc_d           = eff_inc;
    acc_d           = '0;
    os_cnt_d        = '0;
    sample_enable_d = 1'b0;
    tx_enable_d     = 1'b0;
    rate_changed_d  = rate_chg;
    if (!rate_chg && enable) begin
      acc_d           = sum[ACC_WIDTH-1:0];
      sample_enable_d = sum[ACC_WIDTH];
      os_cnt_d        = os_cnt_q;
      if (sum[ACC_WIDTH]) begin
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d    = '0;
          tx_enable_d = 1'b1;
        end else begin
          os_cnt_d    = os_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q           <= '0;
      inc_q           <= '0;
      os_cnt_q        <= '0;
      sample_enable_q <= 1'b0;
      tx_enable_q     <= 1'b0;
      rate_changed_q  <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      inc_q           <= inc_d;
      os_cnt_q        <= os_cnt_d;
      sample_enable_q <= sample_enable_d;
      tx_enable_q     <= tx_enable_d;
      rate_changed_q  <= rate_changed_d;
    end
  end

  assign sample_ENABLE = sample_enable_q;
  assign tx_ENABLE     = tx_enable_q;
  assign rate_changed  = rate_changed_q;

endmodule

// File: tb/tb_baud_generator_frac.sv
// Directed bench for baud_generator_frac: a vector table of rate settings plus sequences for rate change, enable drop and async reset.
module tb_baud_generator_frac;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  baud_select;
  logic        custom_mode;
  logic [23:0] custom_incr;
  logic [31:0] custom_incr2;
  logic        s1, t1, r1;
  logic        s2, t2, r2;

  always #5 clk = ~clk;

  assign custom_incr2 = {8'h00, custom_incr};

  baud_generator_frac dut (
    .clk(clk), .reset(reset), .enable(enable), .baud_select(baud_select),
    .custom_mode(custom_mode), .custom_incr(custom_incr),
    .sample_ENABLE(s1), .tx_ENABLE(t1), .rate_changed(r1)
  );

  baud_generator_frac #(.CLK_FREQ(100000000), .OVERSAMPLE(8), .ACC_WIDTH(32)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .baud_select(baud_select),
    .custom_mode(custom_mode), .custom_incr(custom_incr2),
    .sample_ENABLE(s2), .tx_ENABLE(t2), .rate_changed(r2)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    int first, ns, ntx, rc_first, rc_total, txbad, min_gap, max_gap, first_tx;
    int first2, ns2, ntx2;
  } win_t;

  // Edge 1 is the first rising edge after the call; outputs sampled 1 ns after each edge.
  task automatic run_window(input int n, output win_t w);
    int last;
    w = '{0, 0, 0, 0, 0, 0, 1000000, 0, 0, 0, 0, 0};
    last = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (s1) begin
        w.ns++;
        if (w.first == 0) w.first = k;
        if (last != 0) begin
          if (k - last < w.min_gap) w.min_gap = k - last;
          if (k - last > w.max_gap) w.max_gap = k - last;
        end
        last = k;
      end
      if (t1) begin
        w.ntx++;
        if (w.first_tx == 0) w.first_tx = k;
        if (!s1) w.txbad++;
      end
      if (r1) begin
        w.rc_total++;
        if (k == 1) w.rc_first = 1;
      end
      if (s2) begin
        w.ns2++;
        if (w.first2 == 0) w.first2 = k;
      end
      if (t2) w.ntx2++;
    end
  endtask

  task automatic apply_reset(input logic cm, input logic [2:0] sel, input logic [23:0] inc);
    @(negedge clk);
    reset       = 1'b0;
    enable      = 1'b1;
    custom_mode = cm;
    baud_select = sel;
    custom_incr = inc;
    repeat (40) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        cm;
    logic [2:0]  sel;
    logic [23:0] inc;
    int          first, ns, ntx, rc;
  } vec_t;

  vec_t tbl[8];
  win_t w;
  int   found;

  initial begin
    // Expected values over 1000 edges: first = edge of first pulse, ns = floor(999*inc/2^24), ntx = floor(ns/16).
    tbl[0] = '{1'b0, 3'b111, 24'd0,        29,  36,  2, 1};
    tbl[1] = '{1'b0, 3'b011, 24'd0,        327, 3,   0, 1};
    tbl[2] = '{1'b1, 3'b000, 24'd8388608,  3,   499, 31, 1};
    tbl[3] = '{1'b1, 3'b000, 24'd0,        0,   0,   0, 0};
    tbl[4] = '{1'b1, 3'b000, 24'd16777215, 3,   998, 62, 1};
    tbl[5] = '{1'b1, 3'b000, 24'd12345678, 3,   735, 45, 1};
    tbl[6] = '{1'b0, 3'b000, 24'd0,        0,   0,   0, 1};
    tbl[7] = '{1'b0, 3'b110, 24'd0,        56,  18,  1, 1};

    reset       = 1'b0;
    enable      = 1'b1;
    custom_mode = 1'b0;
    baud_select = 3'b111;
    custom_incr = 24'd0;
    repeat (5) @(negedge clk);
    check("reset_sample", int'(s1), 0);
    check("reset_tx",     int'(t1), 0);
    check("reset_rc",     int'(r1), 0);
    check("reset_dut2",   int'({s2, t2, r2}), 0);

    // Scenario 1: 115200 baud from reset, 10000 clks.
    apply_reset(1'b0, 3'b111, 24'd0);
    run_window(10000, w);
    check("s1_first",   w.first,    29);
    check("s1_samples", w.ns,       368);
    check("s1_tx",      w.ntx,      23);
    check("s1_min_gap", w.min_gap,  27);
    check("s1_max_gap", w.max_gap,  28);
    check("s1_txalign", w.txbad,    0);
    check("s1_rc",      w.rc_total, 1);
    check("os8_first",   w.first2, 110);
    check("os8_samples", w.ns2,    92);
    check("os8_tx",      w.ntx2,   11);

    // Rate change mid-run: strobe-free restart from phase 0.
    @(negedge clk);
    baud_select = 3'b011;
    run_window(400, w);
    check("rc_pulse_edge", w.rc_first, 1);
    check("rc_pulse_once", w.rc_total, 1);
    check("rc_next_sample", w.first, 327);
    check("rc_samples", w.ns, 1);

    // Rate change while disabled still reports; plain disable does not.
    @(negedge clk);
    enable      = 1'b0;
    baud_select = 3'b111;
    run_window(50, w);
    check("dis_rc_first", w.rc_first, 1);
    check("dis_rc_total", w.rc_total, 1);
    check("dis_samples",  w.ns + w.ntx, 0);
    run_window(5, w);
    check("dis_no_rc", w.rc_total, 0);

    for (int i = 0; i < 8; i++) begin
      apply_reset(tbl[i].cm, tbl[i].sel, tbl[i].inc);
      run_window(1000, w);
      check($sformatf("vec%0d_first", i),   w.first,    tbl[i].first);
      check($sformatf("vec%0d_samples", i), w.ns,       tbl[i].ns);
      check($sformatf("vec%0d_tx", i),      w.ntx,      tbl[i].ntx);
      check($sformatf("vec%0d_rc", i),      w.rc_total, tbl[i].rc);
      check($sformatf("vec%0d_txalign", i), w.txbad,    0);
    end

    // Enable dropped mid-bit with half-scale increment: os_cnt must restart.
    apply_reset(1'b1, 3'b000, 24'd8388608);
    run_window(11, w);
    check("en_pre_samples", w.ns, 5);
    @(negedge clk);
    enable = 1'b0;
    run_window(50, w);
    check("en_low_pulses", w.ns + w.ntx + w.rc_total, 0);
    @(negedge clk);
    enable = 1'b1;
    run_window(32, w);
    check("en_post_first",   w.first,    2);
    check("en_post_samples", w.ns,       16);
    check("en_post_tx_edge", w.first_tx, 32);

    // Async reset between edges while sample_ENABLE is high.
    apply_reset(1'b0, 3'b111, 24'd0);
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      @(posedge clk);
      #1;
      if (s1) found = 1;
    end
    check("ar_found_pulse", found, 1);
    reset = 1'b0;
    #1;
    check("ar_outputs_clear", int'({s1, t1, r1}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_window(100, w);
    check("ar_first",   w.first,    29);
    check("ar_samples", w.ns,       3);
    check("ar_tx",      w.ntx,      0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
